// File: rtl/snake_pkg.sv
// Shared direction encodings, PS/2 scancodes and FSM state types for the
// snake PS/2 move encoder.
package snake_pkg;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_LEFT  = 3'd4;

    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BRK      = 8'hF0;
    localparam logic [7:0] SC_P1_UP    = 8'h1D;
    localparam logic [7:0] SC_P1_RIGHT = 8'h23;
    localparam logic [7:0] SC_P1_DOWN  = 8'h1B;
    localparam logic [7:0] SC_P1_LEFT  = 8'h1C;
    localparam logic [7:0] SC_P2_UP    = 8'h75;
    localparam logic [7:0] SC_P2_RIGHT = 8'h74;
    localparam logic [7:0] SC_P2_DOWN  = 8'h72;
    localparam logic [7:0] SC_P2_LEFT  = 8'h6B;
    localparam logic [7:0] SC_SPACE    = 8'h29;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXTBRK} dec_state_t;

    function automatic logic [2:0] opp_dir(input logic [2:0] d);
        case (d)
            DIR_UP:    opp_dir = DIR_DOWN;
            DIR_RIGHT: opp_dir = DIR_LEFT;
            DIR_DOWN:  opp_dir = DIR_UP;
            DIR_LEFT:  opp_dir = DIR_RIGHT;
            default:   opp_dir = DIR_NONE;
        endcase
    endfunction

    function automatic logic [2:0] p1_dir(input logic [7:0] code);
        case (code)
            SC_P1_UP:    p1_dir = DIR_UP;
            SC_P1_RIGHT: p1_dir = DIR_RIGHT;
            SC_P1_DOWN:  p1_dir = DIR_DOWN;
            SC_P1_LEFT:  p1_dir = DIR_LEFT;
            default:     p1_dir = DIR_NONE;
        endcase
    endfunction

    function automatic logic [2:0] p2_dir(input logic [7:0] code);
        case (code)
            SC_P2_UP:    p2_dir = DIR_UP;
            SC_P2_RIGHT: p2_dir = DIR_RIGHT;
            SC_P2_DOWN:  p2_dir = DIR_DOWN;
            SC_P2_LEFT:  p2_dir = DIR_LEFT;
            default:     p2_dir = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, falling-edge detect, 11-bit frame
// FSM with odd-parity/stop checking and a mid-frame inactivity timeout.
module ps2_rx
    import snake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2, clk_d;
    logic          dat_s1, dat_s2;
    logic          fall;
    rx_state_t     state;
    logic [2:0]    count;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcount;

    assign fall = clk_d & ~clk_s2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            clk_d      <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            state      <= RX_IDLE;
            count      <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tcount     <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            clk_d      <= clk_s2;
            dat_s1     <= ps2_data;
            dat_s2     <= dat_s1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tcount <= '0;
                case (state)
                    RX_IDLE: begin
                        if (!dat_s2) begin
                            state <= RX_DATA;
                            count <= '0;
                        end
                    end
                    RX_DATA: begin
                        shreg <= {dat_s2, shreg[7:1]};
                        count <= count + 3'd1;
                        if (count == 3'd7)
                            state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par   <= dat_s2;
                        state <= RX_STOP;
                    end
                    RX_STOP: begin
                        // Odd parity: data plus parity bit must hold an odd number of ones.
                        if (dat_s2 && (^{shreg, par})) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end else if (state != RX_IDLE) begin
                if (tcount == TW'(TIMEOUT_CYCLES)) begin
                    frame_err <= 1'b1;
                    state     <= RX_IDLE;
                    tcount    <= '0;
                    count     <= '0;
                    shreg     <= '0;
                end else begin
                    tcount <= tcount + 1'b1;
                end
            end else begin
                tcount <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_move_encoder.sv
// PS/2 keyboard to snake move encoder: WASD drives move1, arrows drive move2,
// Space pulses restart. Define SNAKE_MOVE_LATCH_EN to commit moves on frame_tick.
module ps2_move_encoder
    import snake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned INIT_MOVE1     = 2,
    parameter int unsigned INIT_MOVE2     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        frame_tick,
    output logic [31:0] move1,
    output logic [31:0] move2,
    output logic        restart,
    output logic        frame_err
);

    logic       byte_valid;
    logic [7:0] rx_byte;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    dec_state_t dec, dec_nxt;
    logic [2:0] m1, m2;
    logic [2:0] req1, req2;
    logic       space;
    logic       acc1, acc2;

    assign move1 = {29'd0, m1};
    assign move2 = {29'd0, m2};

    always_comb begin
        dec_nxt = dec;
        req1    = DIR_NONE;
        req2    = DIR_NONE;
        space   = 1'b0;
        if (byte_valid) begin
            case (dec)
                D_IDLE: begin
                    if (rx_byte == SC_EXT)
                        dec_nxt = D_EXT;
                    else if (rx_byte == SC_BRK)
                        dec_nxt = D_BRK;
                    else begin
                        req1  = p1_dir(rx_byte);
                        space = (rx_byte == SC_SPACE);
                    end
                end
                D_EXT: begin
                    if (rx_byte == SC_BRK)
                        dec_nxt = D_EXTBRK;
                    else begin
                        req2    = p2_dir(rx_byte);
                        dec_nxt = D_IDLE;
                    end
                end
                default: dec_nxt = D_IDLE;
            endcase
        end
    end

    // Reversal is always judged against the committed direction.
    assign acc1 = (req1 != DIR_NONE) && (req1 != opp_dir(m1));
    assign acc2 = (req2 != DIR_NONE) && (req2 != opp_dir(m2));

`ifdef SNAKE_MOVE_LATCH_EN
    logic [2:0] pend1, pend2;

    // A tick commits the pending value held before this cycle; a same-cycle key lands in pending.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dec     <= D_IDLE;
            restart <= 1'b0;
            m1      <= 3'(INIT_MOVE1);
            m2      <= 3'(INIT_MOVE2);
            pend1   <= 3'(INIT_MOVE1);
            pend2   <= 3'(INIT_MOVE2);
        end else begin
            dec     <= dec_nxt;
            restart <= space;
            if (frame_tick) begin
                m1 <= pend1;
                m2 <= pend2;
            end
            if (acc1)
                pend1 <= req1;
            if (acc2)
                pend2 <= req2;
        end
    end
`else
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dec     <= D_IDLE;
            restart <= 1'b0;
            m1      <= 3'(INIT_MOVE1);
            m2      <= 3'(INIT_MOVE2);
        end else begin
            dec     <= dec_nxt;
            restart <= space;
            if (acc1)
                m1 <= req1;
            if (acc2)
                m2 <= req2;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_move_encoder.sv
// Directed bench for ps2_move_encoder: bit-banged PS/2 frames, immediate assertions.
module tb_ps2_move_encoder;

    localparam int unsigned TO = 400;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        frame_tick = 1'b0;
    logic [31:0] move1, move2;
    logic        restart, frame_err;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int rst_high = 0;
    int rst_pulses = 0;
    logic restart_q = 1'b0;
    int e0, r0p, r0h;

    ps2_move_encoder #(
        .TIMEOUT_CYCLES(TO),
        .INIT_MOVE1(2),
        .INIT_MOVE2(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .frame_tick (frame_tick),
        .move1      (move1),
        .move2      (move2),
        .restart    (restart),
        .frame_err  (frame_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (frame_err) err_cnt++;
        if (restart) rst_high++;
        if (restart && !restart_q) rst_pulses++;
        restart_q = restart;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (5) @(posedge clock);
        ps2_clk = 1'b0;
        repeat (10) @(posedge clock);
        ps2_clk = 1'b1;
        repeat (5) @(posedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        repeat (5) @(posedge clock);
    endtask

    task automatic tick();
        @(posedge clock); #1 frame_tick = 1'b1;
        @(posedge clock); #1 frame_tick = 1'b0;
        @(negedge clock);
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 1'b0);
        tick();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("in_reset_move1", move1, 32'd2);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("reset_move1", move1, 32'd2);
        check("reset_move2", move2, 32'd4);
        check("reset_restart", {31'd0, restart}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);

        key(8'h1D); check("w_up", move1, 32'd1);
        key(8'h1B); check("s_reversal", move1, 32'd1);
        key(8'h1C); check("a_left", move1, 32'd4);

        key(8'hE0); key(8'h74); check("right_reversal", move2, 32'd4);
        key(8'hE0); key(8'h75); check("up_arrow", move2, 32'd1);
        key(8'hE0); key(8'hF0); key(8'h75); check("ext_break", move2, 32'd1);
        key(8'hE0); key(8'h6B); check("left_after_break", move2, 32'd4);
        check("p1_untouched_by_arrows", move1, 32'd4);

        key(8'hF0); key(8'h1D); check("w_release", move1, 32'd4);
        r0p = rst_pulses; r0h = rst_high;
        key(8'h29);
        check("restart_pulses", rst_pulses - r0p, 32'd1);
        check("restart_width", rst_high - r0h, 32'd1);

        key(8'h1D); check("w_up_again", move1, 32'd1);
        e0 = err_cnt;
        send_frame(8'h23, 1'b1); tick();
        check("parity_err", err_cnt - e0, 32'd1);
        check("parity_no_move", move1, 32'd1);

        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TO + 60) @(posedge clock);
        @(negedge clock);
        check("timeout_err", err_cnt - e0, 32'd1);
        check("timeout_no_move", move1, 32'd1);
        key(8'h23);
        check("d_after_timeout", move1, 32'd2);
        check("no_extra_err", err_cnt - e0, 32'd1);

`ifdef SNAKE_MOVE_LATCH_EN
        send_frame(8'h1D, 1'b0);
        send_frame(8'h1B, 1'b0);
        @(negedge clock);
        check("latch_hold", move1, 32'd2);
        tick();
        check("latch_commit_last", move1, 32'd3);
        send_frame(8'h1C, 1'b0);
        @(negedge clock);
        check("latch_pend_hold", move1, 32'd3);
        reset = 1'b0;
        #1;
        check("latch_reset_move1", move1, 32'd2);
        check("latch_reset_move2", move2, 32'd4);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("latch_pend_discarded", move1, 32'd2);
`else
        send_frame(8'h1B, 1'b0);
        @(negedge clock);
        check("direct_no_tick", move1, 32'd3);
        reset = 1'b0;
        #1;
        check("async_reset_move1", move1, 32'd2);
        check("async_reset_move2", move2, 32'd4);
        @(negedge clock);
        reset = 1'b1;
`endif

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
